// File: rtl/case3_pkg.sv
// Shared definitions for the case3_pipe slice: lane limits, the single-lane
// result triple and the pure case3 evaluation function.
package case3_pkg;

  localparam int unsigned LANES_MIN = 1;
  localparam int unsigned LANES_MAX = 32;
  localparam int unsigned PCNT_W    = $clog2(LANES_MAX + 1);

  typedef struct packed {
    logic x;
    logic y;
    logic z;
  } case3_bit_t;

  function automatic case3_bit_t case3_eval(
    input logic a, input logic b, input logic c, input logic d,
    input logic e, input logic f, input logic g
  );
    case3_bit_t r;
    logic eg;
    logic ab;
    eg  = e & g;
    ab  = a & b;
    r.x = a & b & c & d & e;
    r.y = b | c | (d ^ f) | (e ^ g);
    r.z = d ? ((eg & ~ab) | (~eg & ~c)) : ((c & ~eg) | (ab & eg));
    return r;
  endfunction

endpackage

// File: rtl/case3_lane_fn.sv
// Combinational single-lane case3 evaluator; mode complements all three results.
module case3_lane_fn (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  input  logic mode,
  output logic x,
  output logic y,
  output logic z
);
  import case3_pkg::*;

  case3_bit_t r;

  always_comb begin
    r = case3_eval(a, b, c, d, e, f, g);
    x = r.x ^ mode;
    y = r.y ^ mode;
    z = r.z ^ mode;
  end

endmodule

// File: rtl/case3_pipe.sv
// Pipelined multi-lane case3 with valid/ready stream and saturating z popcount.
// Optional out_par port enabled by defining CASE3_PIPE_PARITY_EN.
module case3_pipe
  import case3_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] c,
  input  logic [LANES-1:0] d,
  input  logic [LANES-1:0] e,
  input  logic [LANES-1:0] f,
  input  logic [LANES-1:0] g,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] x,
  output logic [LANES-1:0] y,
  output logic [LANES-1:0] z,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] z_count
`ifdef CASE3_PIPE_PARITY_EN
  ,
  output logic [LANES-1:0] out_par
`endif
);

  localparam int unsigned SUM_W = CNT_W + PCNT_W;

  typedef struct packed {
    logic [LANES-1:0] x;
    logic [LANES-1:0] y;
    logic [LANES-1:0] z;
`ifdef CASE3_PIPE_PARITY_EN
    logic [LANES-1:0] par;
`endif
  } stage_t;

  logic             advance;
  logic [LANES-1:0] fx, fy, fz;
  stage_t           fn_res;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    case3_lane_fn u_lane (
      .a(a[i]), .b(b[i]), .c(c[i]), .d(d[i]), .e(e[i]), .f(f[i]), .g(g[i]),
      .mode(mode), .x(fx[i]), .y(fy[i]), .z(fz[i])
    );
  end

  always_comb begin
    fn_res   = '0;
    fn_res.x = fx;
    fn_res.y = fy;
    fn_res.z = fz;
`ifdef CASE3_PIPE_PARITY_EN
    fn_res.par = fx ^ fy ^ fz;
`endif
  end

  // Every stage shifts on the shared advance; stage 0 captures the function cone.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic   vld_d, vld_q;
    stage_t pay_d, pay_q;

    if (s == 0) begin : g_head
      always_comb begin
        vld_d = advance ? in_valid : vld_q;
        pay_d = advance ? fn_res : pay_q;
      end
    end else begin : g_tail
      always_comb begin
        vld_d = advance ? g_stage[s-1].vld_q : vld_q;
        pay_d = advance ? g_stage[s-1].pay_q : pay_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        pay_q <= '0;
      end else begin
        vld_q <= vld_d;
        pay_q <= pay_d;
      end
    end
  end

  always_comb begin
    out_valid = g_stage[STAGES-1].vld_q;
    x         = g_stage[STAGES-1].pay_q.x;
    y         = g_stage[STAGES-1].pay_q.y;
    z         = g_stage[STAGES-1].pay_q.z;
`ifdef CASE3_PIPE_PARITY_EN
    out_par   = g_stage[STAGES-1].pay_q.par;
`endif
    advance   = ~out_valid | out_ready;
    in_ready  = advance;
  end

  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [PCNT_W-1:0] z_pop;
  logic [SUM_W-1:0]  sum;

  // Clear applies before the add, so a coincident beat lands on a zero base.
  always_comb begin
    z_pop = PCNT_W'($countones(z));
    sum   = '0;
    cnt_d = cnt_clr ? '0 : cnt_q;
    if (out_valid && out_ready) begin
      sum   = SUM_W'(cnt_d) + SUM_W'(z_pop);
      cnt_d = (sum[SUM_W-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb z_count = cnt_q;

endmodule

// File: tb/tb_case3_pipe.sv
// Directed bench for case3_pipe (LANES=4, STAGES=2, CNT_W=4) with a queue scoreboard.
module tb_case3_pipe;

  localparam int unsigned LANES  = 4;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, mode, out_valid, out_ready, cnt_clr;
  logic [3:0] a, b, c, d, e, f, g, x, y, z;
  logic [3:0] z_count;
`ifdef CASE3_PIPE_PARITY_EN
  logic [3:0] out_par;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
  } res_t;

  res_t       exp_q[$];
  logic [3:0] exp_cnt  = '0;
  logic       mon_live = 1'b0;

  always #5 clk = ~clk;

  case3_pipe #(.LANES(LANES), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .y(y), .z(z), .cnt_clr(cnt_clr), .z_count(z_count)
`ifdef CASE3_PIPE_PARITY_EN
    , .out_par(out_par)
`endif
  );

  function automatic res_t model(input logic [3:0] ma, input logic [3:0] mb,
                                 input logic [3:0] mc, input logic [3:0] md,
                                 input logic [3:0] me, input logic [3:0] mf,
                                 input logic [3:0] mg, input logic mm);
    res_t r;
    for (int i = 0; i < 4; i++) begin
      logic eg, ab;
      eg = me[i] & mg[i];
      ab = ma[i] & mb[i];
      r.x[i] = ma[i] & mb[i] & mc[i] & md[i] & me[i];
      r.y[i] = mb[i] | mc[i] | (md[i] ^ mf[i]) | (me[i] ^ mg[i]);
      if (!md[i]) r.z[i] = (mc[i] & ~eg) | (ab & eg);
      else        r.z[i] = (eg & ~ab) | (~eg & ~mc[i]);
    end
    if (mm) r = ~r;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] sc,
                          input logic [3:0] sd, input logic [3:0] se, input logic [3:0] sf,
                          input logic [3:0] sg, input logic sm);
    a = sa; b = sb; c = sc; d = sd; e = se; f = sf; g = sg; mode = sm;
  endtask

  task automatic set_rand();
    set_beat(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
  endtask

  // Single accepted beat, checked against constants two cycles after acceptance.
  task automatic beat_check(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                            input logic [3:0] ez);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_early"}, out_valid, 1'b0);
    step();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_x"}, x, ex);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_z"}, z, ez);
    step();
  endtask

  // Scoreboard: push on input handshake, pop/compare on output handshake.
  task automatic monitor();
    res_t       r;
    logic [3:0] base;
    logic [5:0] s;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_cnt  = '0;
        mon_live = 1'b1;
      end else if (mon_live) begin
        chk("z_count", z_count, exp_cnt);
        chk("in_ready", in_ready, (!out_valid || out_ready));
        base = cnt_clr ? 4'd0 : exp_cnt;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("stale_beat", out_valid, 1'b0);
          end else if (out_ready) begin
            r = exp_q.pop_front();
            chk("sb_x", x, r.x);
            chk("sb_y", y, r.y);
            chk("sb_z", z, r.z);
`ifdef CASE3_PIPE_PARITY_EN
            chk("sb_par", out_par, r.x ^ r.y ^ r.z);
`endif
            s    = 6'(base) + 6'($countones(r.z));
            base = (s > 6'd15) ? 4'hf : s[3:0];
          end
        end
        exp_cnt = base;
        if (in_valid && (!out_valid || out_ready))
          exp_q.push_back(model(a, b, c, d, e, f, g, mode));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] vbits;
    logic [11:0] snap;
    logic        ovseen;
    int          sat_tab[5];
    sat_tab = '{4, 8, 12, 15, 15};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    set_beat('0, '0, '0, '0, '0, '0, '0, 1'b0);
    fork
      monitor();
    join_none

    repeat (3) step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_xyz", {x, y, z}, 12'h000);
    chk("rst_z_count", z_count, 4'd0);
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef CASE3_PIPE_PARITY_EN
    chk("rst_par", out_par, 4'h0);
`endif
    rst = 1'b0;
    step();

    set_beat(4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    beat_check("lane0_all", 4'b0000 | 4'b0001, 4'b0001, 4'b0000);

    set_beat(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    beat_check("z_c_path", 4'b0000, 4'b0001, 4'b0001);
    set_beat(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    beat_check("z_abeg_path", 4'b0000, 4'b0001, 4'b0001);
    set_beat(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    beat_check("mode_inv", 4'b1111, 4'b1110, 4'b1110);

    vbits = '0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        set_rand();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      vbits = {out_valid, vbits[11:1]};
    end
    chk("b2b_valid_train", vbits, 12'h1fe);

    out_ready = 1'b1;
    set_rand(); in_valid = 1'b1;
    step();
    set_rand();
    step();
    chk("stall_fill", out_valid, 1'b1);
    out_ready = 1'b0;
    set_rand();
    snap = {x, y, z};
    repeat (5) begin
      step();
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_hold", {x, y, z}, snap);
    end
    out_ready = 1'b1;
    repeat (3) begin
      step();
      set_rand();
    end
    in_valid = 1'b0;
    repeat (5) step();
    chk("drain_empty", exp_q.size(), 0);

    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_zero", z_count, 4'd0);
    set_beat(4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("sat_count", z_count, sat_tab[i]);
    end
    set_beat(4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_plus_beat", z_count, 4'd2);

    out_ready = 1'b0;
    set_rand(); in_valid = 1'b1;
    step();
    set_rand();
    step();
    in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1'b1);
    rst = 1'b1;
    step();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_z_count", z_count, 4'd0);
    chk("midrst_xyz", {x, y, z}, 12'h000);
    chk("midrst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    out_ready = 1'b1;
    ovseen = 1'b0;
    repeat (6) begin
      step();
      ovseen = ovseen | out_valid;
    end
    chk("no_stale_after_rst", ovseen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
